uart_rx_frame: RTL
==================

// Module: uart_rx_frame
// PURPOSE
//  Receive side of the RS-232 link: a 16x-oversampling byte receiver with majority-vote
//  sampling, optional parity, framing/overrun detection and a valid/ready byte holding register.
//  Sits between the Rs232_Rx pin (or a Tx loopback) and the byte consumer.
//  Pairs with uart_byte_tx on the same baud_set encoding.
// PARAMETERS
//  CLK_HZ     50_000_000  system clock frequency; the divisor table below assumes this value
//  PARITY_EN  0           1 = a parity bit follows D7; 0 = no parity bit
//  PARITY_ODD 0           1 = odd parity, 0 = even parity (ignored if PARITY_EN=0)
// PORTS
//  Clk         in   1  system clock, 50 MHz
//  Rst_n       in   1  asynchronous active-low reset
//  baud_set    in   3  0:9600 1:19200 2:38400 3:57600 4:115200; values 5-7 select 9600
//  Rs232_Rx    in   1  serial line, idle high, asynchronous to Clk
//  data_byte   out  8  last received byte; valid while rx_valid=1
//  rx_valid    out  1  holding register full
//  rx_ready    in   1  consumer accepts the byte when rx_valid & rx_ready
//  Rx_Done     out  1  1-clk pulse when a frame completes (good or bad)
//  parity_err  out  1  parity status of the held byte (0 if PARITY_EN=0)
//  frame_err   out  1  1-clk pulse: stop bit sampled 0
//  overrun     out  1  1-clk pulse: frame completed while rx_valid=1
//  busy        out  1  FSM not in IDLE
// BEHAVIOUR
//  - Reset (async): FSM=IDLE; all outputs 0; data_byte=8'h00; synchroniser flops=1.
//  - Rs232_Rx passes through a 2-flop synchroniser plus 1 history flop.
//    Falling edge = history 1 & sync 0.
//  - Tick divisor DIV (16x): 9600:326 19200:163 38400:81 57600:54 115200:27.
//    Tick counter runs 0..DIV-1; its wrap is one subtick; each bit lasts 16 subticks (0..15).
//  - baud_set is latched on leaving IDLE; changes mid-frame take effect on the next frame.
//  - FSM states:
//    - IDLE: on a falling edge, clear counters and go to START.
//    - START: sample subticks 7,8,9 and take the majority vote at the end of subtick 9.
//      Majority 1 = false start: go to IDLE with no flags set. Otherwise continue to subtick 15, then DATA.
//    - DATA: 8 bits, LSB first. Each bit is the majority of subticks 7,8,9, shifted in at subtick 15.
//      After bit 7, go to PARITY if PARITY_EN, else STOP.
//    - PARITY: majority sample at subticks 7-9; err = (^data ^ pbit) != PARITY_ODD.
//      Go to STOP at subtick 15.
//    - STOP: majority decided at the end of subtick 9; complete the frame in that same cycle, then IDLE.
//      IDLE is entered mid stop bit, which tolerates a transmitter up to ~3% fast.
//  - Frame completion (single cycle):
//    - Rx_Done=1.
//    - If the stop bit is 0, frame_err=1 and the byte is still delivered.
//    - If rx_valid=0, or rx_valid & rx_ready in the same cycle: load data_byte and parity_err,
//      and rx_valid=1.
//    - If rx_valid=1 & rx_ready=0: overrun=1; the new byte is dropped and the held byte is kept.
//  - Handshake: rx_valid clears the cycle after rx_valid & rx_ready. data_byte is stable while rx_valid=1.
//  - Line held low (break): the frame ends with frame_err and data 8'h00. IDLE then waits for a
//    falling edge, so no further frames occur until the line returns high.
//  - Latency: Rx_Done is asserted 9*16+9 subticks (+3 clk of synchroniser delay) after the start edge.
// STRUCTURE
//  - Shared package uart_pkg:
//    - baud divisor function div_16x(baud_set)
//    - FSM state enum {IDLE,START,DATA,PARITY,STOP}
//    - the baud_set code constants shared with uart_byte_tx
//  - One sub-module, uart_baud_tick: latched divisor, tick counter, 1-clk tick pulse,
//    synchronous clear.
//  - FSM, subtick/bit counters, vote register, shifter and holding register stay in uart_rx_frame.
// TESTING
//  - 115200, 8N1, byte 8'hA5 driven by a model; rx_ready=0 -> Rx_Done pulses once,
//    data_byte=8'hA5, rx_valid=1, no error flags.
//  - Loopback from uart_byte_tx at 9600: bytes 8'h00, 8'hFF, 8'h55 back-to-back;
//    rx_ready pulses after each -> bytes received in order, overrun never asserted.
//  - Glitch: a 1-subtick low pulse on an idle line -> false start; returns to IDLE with
//    no Rx_Done and busy low within 10 subticks.
//  - Two frames with rx_ready held 0 -> the second completion pulses overrun;
//    data_byte keeps the first value.
//  - Stop bit forced 0 on 8'h3C -> frame_err and Rx_Done in the same cycle;
//    data_byte=8'h3C, rx_valid=1.
//  - PARITY_EN=1, PARITY_ODD=0, 8'h07 sent with parity bit 0 -> parity_err=1.
//    Reset asserted mid-DATA -> all outputs 0 and IDLE immediately.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the UART byte receiver and transmitter: baud_set codes,
// receiver FSM states and the 16x oversampling divisor lookup.
package uart_pkg;

    localparam logic [2:0] BAUD_9600   = 3'd0;
    localparam logic [2:0] BAUD_19200  = 3'd1;
    localparam logic [2:0] BAUD_38400  = 3'd2;
    localparam logic [2:0] BAUD_57600  = 3'd3;
    localparam logic [2:0] BAUD_115200 = 3'd4;

    localparam int DIV_W = 9;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } rx_state_e;

    // Rounded clk_hz / (16 * baud); each arm folds to a constant for a fixed clock.
    // At 50 MHz this yields 326/163/81/54/27. Unused codes fall back to 9600.
    function automatic logic [DIV_W-1:0] div_16x(input logic [2:0] baud_set,
                                                 input int unsigned clk_hz);
        int unsigned div;
        case (baud_set)
            BAUD_19200:  div = (clk_hz + 8 * 19_200)  / (16 * 19_200);
            BAUD_38400:  div = (clk_hz + 8 * 38_400)  / (16 * 38_400);
            BAUD_57600:  div = (clk_hz + 8 * 57_600)  / (16 * 57_600);
            BAUD_115200: div = (clk_hz + 8 * 115_200) / (16 * 115_200);
            default:     div = (clk_hz + 8 * 9_600)   / (16 * 9_600);
        endcase
        return DIV_W'(div);
    endfunction

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// 16x oversampling tick generator: divisor latched on load_i, counter runs 0..DIV-1
// and tick_o marks the last count of each subtick.
module uart_baud_tick
    import uart_pkg::*;
#(
    parameter int unsigned CLK_HZ = 50_000_000
) (
    input  logic       Clk,
    input  logic       Rst_n,
    input  logic       clr_i,
    input  logic       load_i,
    input  logic [2:0] baud_set_i,
    output logic       tick_o
);

    logic [DIV_W-1:0] div_q;
    logic [DIV_W-1:0] cnt_q;

    assign tick_o = (cnt_q == div_q - 1'b1);

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            div_q <= div_16x(BAUD_9600, CLK_HZ);
            cnt_q <= '0;
        end else begin
            if (load_i) begin
                div_q <= div_16x(baud_set_i, CLK_HZ);
            end
            if (clr_i || tick_o) begin
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_rx_frame.sv
// 16x oversampling UART byte receiver with 3-sample majority vote, optional parity,
// framing/overrun flags and a valid/ready holding register.
//   state  | meaning
//   IDLE   | line idle, waiting for a falling edge
//   START  | start bit; majority 1 at subtick 9 aborts as a false start
//   DATA   | 8 data bits, LSB first, shifted in at subtick 15
//   PARITY | parity bit checked against the shifted byte
//   STOP   | stop bit; frame completes at subtick 9
module uart_rx_frame
    import uart_pkg::*;
#(
    parameter int unsigned CLK_HZ     = 50_000_000,
    parameter bit          PARITY_EN  = 1'b0,
    parameter bit          PARITY_ODD = 1'b0
) (
    input  logic       Clk,
    input  logic       Rst_n,
    input  logic [2:0] baud_set,
    input  logic       Rs232_Rx,
    output logic [7:0] data_byte,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       Rx_Done,
    output logic       parity_err,
    output logic       frame_err,
    output logic       overrun,
    output logic       busy
);

    logic       sync1_q, sync2_q, hist_q;
    rx_state_e  state_q;
    logic [3:0] subtick_q;
    logic [2:0] bitcnt_q;
    logic [1:0] vote_q;
    logic       bit_q;
    logic [7:0] shift_q;
    logic       perr_frame_q;
    logic [7:0] data_q;
    logic       valid_q;
    logic       perr_q;
    logic       done_q;
    logic       ferr_q;
    logic       ovr_q;

    logic fall;
    logic start_frame;
    logic tick;
    logic at_decide;
    logic at_end;
    logic maj_now;

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            hist_q  <= 1'b1;
        end else begin
            sync1_q <= Rs232_Rx;
            sync2_q <= sync1_q;
            hist_q  <= sync2_q;
        end
    end

    assign fall        = hist_q & ~sync2_q;
    assign start_frame = (state_q == IDLE) && fall;

    uart_baud_tick #(
        .CLK_HZ (CLK_HZ)
    ) u_tick (
        .Clk        (Clk),
        .Rst_n      (Rst_n),
        .clr_i      (start_frame),
        .load_i     (start_frame),
        .baud_set_i (baud_set),
        .tick_o     (tick)
    );

    assign at_decide = tick && (subtick_q == 4'd9);
    assign at_end    = tick && (subtick_q == 4'd15);
    // Vote uses the two stored samples plus the live subtick-9 sample.
    assign maj_now   = maj3(vote_q[0], vote_q[1], sync2_q);

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q      <= IDLE;
            subtick_q    <= '0;
            bitcnt_q     <= '0;
            vote_q       <= '0;
            bit_q        <= 1'b0;
            shift_q      <= '0;
            perr_frame_q <= 1'b0;
            data_q       <= '0;
            valid_q      <= 1'b0;
            perr_q       <= 1'b0;
            done_q       <= 1'b0;
            ferr_q       <= 1'b0;
            ovr_q        <= 1'b0;
        end else begin
            done_q <= 1'b0;
            ferr_q <= 1'b0;
            ovr_q  <= 1'b0;
            if (valid_q && rx_ready) begin
                valid_q <= 1'b0;
            end
            if (tick && state_q != IDLE) begin
                subtick_q <= subtick_q + 4'd1;
            end
            if (tick && subtick_q == 4'd7) begin
                vote_q[0] <= sync2_q;
            end
            if (tick && subtick_q == 4'd8) begin
                vote_q[1] <= sync2_q;
            end
            case (state_q)
                IDLE: begin
                    if (fall) begin
                        state_q      <= START;
                        subtick_q    <= '0;
                        bitcnt_q     <= '0;
                        perr_frame_q <= 1'b0;
                    end
                end
                START: begin
                    if (at_decide && maj_now) begin
                        state_q <= IDLE;
                    end else if (at_end) begin
                        state_q <= DATA;
                    end
                end
                DATA: begin
                    if (at_decide) begin
                        bit_q <= maj_now;
                    end
                    if (at_end) begin
                        shift_q  <= {bit_q, shift_q[7:1]};
                        bitcnt_q <= bitcnt_q + 3'd1;
                        if (bitcnt_q == 3'd7) begin
                            state_q <= PARITY_EN ? PARITY : STOP;
                        end
                    end
                end
                PARITY: begin
                    if (at_decide) begin
                        perr_frame_q <= ((^shift_q) ^ maj_now) != PARITY_ODD;
                    end
                    if (at_end) begin
                        state_q <= STOP;
                    end
                end
                STOP: begin
                    // Completing mid stop bit leaves margin for a slightly fast sender.
                    if (at_decide) begin
                        state_q <= IDLE;
                        done_q  <= 1'b1;
                        ferr_q  <= ~maj_now;
                        if (!valid_q || rx_ready) begin
                            data_q  <= shift_q;
                            perr_q  <= perr_frame_q;
                            valid_q <= 1'b1;
                        end else begin
                            ovr_q <= 1'b1;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign data_byte  = data_q;
    assign rx_valid   = valid_q;
    assign Rx_Done    = done_q;
    assign parity_err = perr_q;
    assign frame_err  = ferr_q;
    assign overrun    = ovr_q;
    assign busy       = (state_q != IDLE);

endmodule
